doce_rx_frame_filter: RTL and testbench

Ingress Ethernet frame filter between the 10G MAC receive AXI-Stream and the DoCE transport layer's 64-bit `doce_axis_rxd_*` input. It buffers the first two 64-bit beats of each frame, checks the destination MAC and EtherType, then either forwards the whole frame unchanged or silently consumes it. It also keeps saturating pass/drop statistics.

---
 rtl/doce_rx_frame_filter.sv | 149 ++++++++++++++
 tb/tb_doce_rx_frame_filter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/doce_rx_frame_filter.sv
// doce_rx_frame_filter: ingress filter between the MAC RX stream and the DoCE transport.
// Buffers the first two beats of each frame, checks destination MAC and EtherType, then
// forwards the whole frame unchanged or silently consumes it.
// Optional macro DOCE_RX_FILTER_STATS_EN enables the saturating pass/drop counters;
// without it both statistics outputs are tied to zero.
module doce_rx_frame_filter #(
  parameter logic [15:0] DOCE_ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] doce_mac_addr,
  input  logic [63:0] mac_axis_rxd_tdata,
  input  logic [7:0]  mac_axis_rxd_tkeep,
  input  logic        mac_axis_rxd_tlast,
  input  logic        mac_axis_rxd_tvalid,
  output logic        mac_axis_rxd_tready,
  output logic [63:0] doce_axis_rxd_tdata,
  output logic [7:0]  doce_axis_rxd_tkeep,
  output logic        doce_axis_rxd_tlast,
  output logic        doce_axis_rxd_tvalid,
  input  logic        doce_axis_rxd_tready,
  output logic [31:0] stat_pass_cnt,
  output logic [31:0] stat_drop_cnt
);

  typedef enum logic [2:0] {StHdr0, StHdr1, StFwd0, StFwd1, StPass, StDrop} state_e;

  state_e      state_q, state_d;
  logic [63:0] hold0_data_q, hold1_data_q;
  logic [7:0]  hold0_keep_q, hold1_keep_q;
  logic        in_hs;
  logic [47:0] dst_mac;
  logic [15:0] ether_type;
  logic        hdr_match;

  assign in_hs = mac_axis_rxd_tvalid && mac_axis_rxd_tready;

  // Byte 0 on the wire is the most significant MAC byte.
  assign dst_mac = {hold0_data_q[7:0],   hold0_data_q[15:8],  hold0_data_q[23:16],
                    hold0_data_q[31:24], hold0_data_q[39:32], hold0_data_q[47:40]};
  assign ether_type = {mac_axis_rxd_tdata[39:32], mac_axis_rxd_tdata[47:40]};
  assign hdr_match  = ((dst_mac == doce_mac_addr) || (dst_mac == 48'hFFFF_FFFF_FFFF)) &&
                      (ether_type == DOCE_ETHERTYPE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StHdr0;
    else       state_q <= state_d;
  end

  // Next-state logic; a tlast on either header beat is a runt and always dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr0: if (in_hs && !mac_axis_rxd_tlast) state_d = StHdr1;
      StHdr1: begin
        if (in_hs) begin
          if (mac_axis_rxd_tlast) state_d = StHdr0;
          else if (hdr_match)     state_d = StFwd0;
          else                    state_d = StDrop;
        end
      end
      StFwd0: if (doce_axis_rxd_tready) state_d = StFwd1;
      StFwd1: if (doce_axis_rxd_tready) state_d = StPass;
      StPass: if (in_hs && mac_axis_rxd_tlast) state_d = StHdr0;
      StDrop: if (in_hs && mac_axis_rxd_tlast) state_d = StHdr0;
      default: state_d = StHdr0;
    endcase
  end

  // Outputs: replay the held header beats, then pass the stream straight through.
  always_comb begin
    mac_axis_rxd_tready  = 1'b0;
    doce_axis_rxd_tvalid = 1'b0;
    doce_axis_rxd_tdata  = 64'd0;
    doce_axis_rxd_tkeep  = 8'd0;
    doce_axis_rxd_tlast  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StHdr0, StHdr1, StDrop: mac_axis_rxd_tready = 1'b1;
        StFwd0: begin
          doce_axis_rxd_tvalid = 1'b1;
          doce_axis_rxd_tdata  = hold0_data_q;
          doce_axis_rxd_tkeep  = hold0_keep_q;
        end
        StFwd1: begin
          doce_axis_rxd_tvalid = 1'b1;
          doce_axis_rxd_tdata  = hold1_data_q;
          doce_axis_rxd_tkeep  = hold1_keep_q;
        end
        StPass: begin
          mac_axis_rxd_tready  = doce_axis_rxd_tready;
          doce_axis_rxd_tvalid = mac_axis_rxd_tvalid;
          doce_axis_rxd_tdata  = mac_axis_rxd_tdata;
          doce_axis_rxd_tkeep  = mac_axis_rxd_tkeep;
          doce_axis_rxd_tlast  = mac_axis_rxd_tlast;
        end
        default: ;
      endcase
    end
  end

  // Header holding registers, loaded only while the matching header beat is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold0_data_q <= 64'd0;
      hold0_keep_q <= 8'd0;
      hold1_data_q <= 64'd0;
      hold1_keep_q <= 8'd0;
    end else if (in_hs) begin
      if (state_q == StHdr0) begin
        hold0_data_q <= mac_axis_rxd_tdata;
        hold0_keep_q <= mac_axis_rxd_tkeep;
      end
      if (state_q == StHdr1) begin
        hold1_data_q <= mac_axis_rxd_tdata;
        hold1_keep_q <= mac_axis_rxd_tkeep;
      end
    end
  end

`ifdef DOCE_RX_FILTER_STATS_EN
  logic        pass_evt, drop_evt;
  logic [31:0] pass_cnt_q, drop_cnt_q;

  // Pass counts on frame completion; drop counts on the consuming tlast.
  assign pass_evt = in_hs && mac_axis_rxd_tlast && (state_q == StPass);
  assign drop_evt = in_hs && mac_axis_rxd_tlast &&
                    ((state_q == StHdr0) || (state_q == StHdr1) || (state_q == StDrop));

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt_q <= 32'd0;
      drop_cnt_q <= 32'd0;
    end else begin
      if (pass_evt && (pass_cnt_q != 32'hFFFF_FFFF)) pass_cnt_q <= pass_cnt_q + 32'd1;
      if (drop_evt && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign stat_pass_cnt = pass_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_pass_cnt = 32'd0;
  assign stat_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_doce_rx_frame_filter.sv
// Directed bench for doce_rx_frame_filter with a frame-level reference model.
module tb_doce_rx_frame_filter;

  localparam logic [47:0] MyMac = 48'h0A0B0C0D0E0F;
  localparam logic [15:0] DoceEt = 16'h88B5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] mac_tdata = '0;
  logic [7:0]  mac_tkeep = '0;
  logic        mac_tlast = 1'b0;
  logic        mac_tvalid = 1'b0;
  logic        mac_tready;
  logic [63:0] doce_tdata;
  logic [7:0]  doce_tkeep;
  logic        doce_tlast;
  logic        doce_tvalid;
  logic        doce_tready = 1'b1;
  logic [31:0] stat_pass_cnt, stat_drop_cnt;

  doce_rx_frame_filter #(.DOCE_ETHERTYPE(DoceEt)) dut (
    .clk                  (clk),
    .reset                (reset),
    .doce_mac_addr        (MyMac),
    .mac_axis_rxd_tdata   (mac_tdata),
    .mac_axis_rxd_tkeep   (mac_tkeep),
    .mac_axis_rxd_tlast   (mac_tlast),
    .mac_axis_rxd_tvalid  (mac_tvalid),
    .mac_axis_rxd_tready  (mac_tready),
    .doce_axis_rxd_tdata  (doce_tdata),
    .doce_axis_rxd_tkeep  (doce_tkeep),
    .doce_axis_rxd_tlast  (doce_tlast),
    .doce_axis_rxd_tvalid (doce_tvalid),
    .doce_axis_rxd_tready (doce_tready),
    .stat_pass_cnt        (stat_pass_cnt),
    .stat_drop_cnt        (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    exp_pass = 0;
  int    exp_drop = 0;
  logic  toggle_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Counters read back as zero when the statistics block is compiled out.
  function automatic logic [31:0] stat_exp(input int v);
`ifdef DOCE_RX_FILTER_STATS_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  // Every output handshake must match the next expected beat; stalled outputs must hold.
  logic        prev_stall = 1'b0;
  logic [72:0] prev_bus = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(doce_tvalid), 128'(1'b1));
        check("stall_bus", 128'({doce_tdata, doce_tkeep, doce_tlast}), 128'(prev_bus));
      end
      if (doce_tvalid && doce_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none", doce_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_beat", 128'({doce_tdata, doce_tkeep, doce_tlast}), 128'({e.d, e.k, e.l}));
        end
      end
      prev_stall = doce_tvalid && !doce_tready;
      prev_bus   = {doce_tdata, doce_tkeep, doce_tlast};
    end
  end

  // Downstream ready pattern 1010... when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) doce_tready = ~doce_tready;
    end
  end

  // Sends beats [0, lim) of an n-beat frame; the model decides pass/drop from the header fields.
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int n,
                            input logic [7:0] last_keep, input int lim, output int cycles);
    logic [63:0] d[16];
    logic [7:0]  k[16];
    logic        pass;
    logic        acc;
    cycles = 0;
    d[0] = {16'hCAFE, dst[7:0], dst[15:8], dst[23:16], dst[31:24], dst[39:32], dst[47:40]};
    d[1] = {16'h1234, et[7:0], et[15:8], 32'hBEEF_0001};
    for (int i = 2; i < 16; i++) d[i] = {32'(n * 16 + i), 32'h5A00_0000 + 32'(i)};
    for (int i = 0; i < 16; i++) k[i] = (i == n - 1) ? last_keep : 8'hFF;
    pass = ((dst == MyMac) || (dst == 48'hFFFF_FFFF_FFFF)) && (et == DoceEt) && (n >= 3);
    if (pass) for (int i = 0; i < lim; i++) exp_q.push_back('{d[i], k[i], i == n - 1});
    if (lim == n) begin
      if (pass) exp_pass++;
      else      exp_drop++;
    end
    for (int i = 0; i < lim; i++) begin
      mac_tdata  = d[i];
      mac_tkeep  = k[i];
      mac_tlast  = (i == n - 1);
      mac_tvalid = 1'b1;
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk);
        acc = mac_tready;
        @(posedge clk);
        #1;
        cycles++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: beat %0d not accepted, expected accept", i);
        mac_tvalid = 1'b0;
        return;
      end
      if (i == 1 && pass) begin
        check("lat_valid", 128'(doce_tvalid), 128'(1'b1));
        check("lat_beat0", 128'(doce_tdata), 128'(d[0]));
        check("lat_in_blocked", 128'(mac_tready), 128'(1'b0));
      end
    end
    mac_tvalid = 1'b0;
    mac_tlast  = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pass_model"}, 128'(stat_pass_cnt), 128'(stat_exp(exp_pass)));
    check({tag, "_drop_model"}, 128'(stat_drop_cnt), 128'(stat_exp(exp_drop)));
    check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int cyc;
    int cyc2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(mac_tready), 128'(1'b0));
    check("rst_out_valid", 128'(doce_tvalid), 128'(1'b0));
    reset = 1'b0;
    #1;
    check("rst_out_bus", 128'({doce_tdata, doce_tkeep, doce_tlast}), 128'(0));
    check("rst_pass", 128'(stat_pass_cnt), 128'(0));
    check("rst_drop", 128'(stat_drop_cnt), 128'(0));
    check("idle_in_ready", 128'(mac_tready), 128'(1'b1));

    // Unicast match: 8 beats, 2 idle input cycles of overhead.
    send_frame(MyMac, DoceEt, 8, 8'h0F, 8, cyc);
    check("uni_cycles", 128'(cyc), 128'(10));
    check_stats("uni");
    check("uni_pass_lit", 128'(stat_pass_cnt), 128'(stat_exp(1)));

    // Wrong EtherType: accepted every cycle, nothing out.
    send_frame(MyMac, 16'h0800, 6, 8'hFF, 6, cyc);
    check("et_cycles", 128'(cyc), 128'(6));
    check_stats("et");
    check("et_drop_lit", 128'(stat_drop_cnt), 128'(stat_exp(1)));

    // Broadcast forwarded, foreign unicast dropped, back to back.
    send_frame(48'hFFFF_FFFF_FFFF, DoceEt, 5, 8'h01, 5, cyc);
    send_frame(48'h112233445566, DoceEt, 4, 8'hFF, 4, cyc2);
    check("bc_cycles", 128'(cyc + cyc2), 128'(7 + 4));
    check_stats("bc");
    check("bc_pass_lit", 128'(stat_pass_cnt), 128'(stat_exp(2)));
    check("bc_drop_lit", 128'(stat_drop_cnt), 128'(stat_exp(2)));

    // Runts: a 1-beat frame and a 2-beat matching frame.
    send_frame(MyMac, DoceEt, 1, 8'h3F, 1, cyc);
    send_frame(MyMac, DoceEt, 2, 8'hFF, 2, cyc2);
    check("runt_cycles", 128'(cyc + cyc2), 128'(3));
    check_stats("runt");
    check("runt_drop_lit", 128'(stat_drop_cnt), 128'(stat_exp(4)));

    // Downstream ready toggling over a 10-beat matching frame.
    toggle_en = 1'b1;
    send_frame(MyMac, DoceEt, 10, 8'h7F, 10, cyc);
    toggle_en = 1'b0;
    doce_tready = 1'b1;
    check_stats("tog");
    check("tog_pass_lit", 128'(stat_pass_cnt), 128'(stat_exp(3)));

    // Reset during pass-through of a frame, then a clean matching frame.
    send_frame(MyMac, DoceEt, 6, 8'hFF, 3, cyc);
    mac_tdata  = 64'hDEAD_BEEF_0000_0003;
    mac_tkeep  = 8'hFF;
    mac_tvalid = 1'b1;
    reset      = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(doce_tvalid), 128'(1'b0));
    check("mid_rst_in_ready", 128'(mac_tready), 128'(1'b0));
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 128'(doce_tvalid), 128'(1'b0));
    mac_tvalid = 1'b0;
    reset = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
    #1;
    check("post_rst_pass", 128'(stat_pass_cnt), 128'(0));
    check("post_rst_drop", 128'(stat_drop_cnt), 128'(0));
    send_frame(MyMac, DoceEt, 4, 8'h03, 4, cyc);
    check_stats("rst");
    check("rst_pass_lit", 128'(stat_pass_cnt), 128'(stat_exp(1)));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
